io_trace_recorder: RTL
======================

Name: io_trace_recorder

Overview:
- Capture side of the replay flow: samples a target signal vector on each fired target cycle and buffers it as timestamped records in a ring FIFO.
- A host-side reader drains the records through a ready/valid port and writes the trace that the replay bench later re-drives.
- Also records the target's exit event, with its exit code, as a terminating marker record.
- Sits next to the DUT wrapper in the simulation harness, on the same clock as the target.

Parameters:
- SIG_W, 64, width of the sampled signal vector.
- DEPTH, 16, FIFO entries; power of two, at least 4.
- CYC_W, 32, width of the target cycle counter and timestamps.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- tgt_fire  in  1  target cycle advances this clock; sampling is qualified by it.
- sig_in  in  SIG_W  signal snapshot for the current target cycle.
- exit  in  1  target requests termination; sampled only with tgt_fire.
- exitcode  in  32  exit code, valid with exit.
- arm  in  1  single-cycle pulse that arms recording.
- start_cycle  in  CYC_W  first target cycle to record; sampled on arm.
- stop_cycle  in  CYC_W  last target cycle to record, inclusive; sampled on arm.
- rec_valid  out  1  head record available.
- rec_ready  in  1  reader accepts the head record.
- rec_data  out  1+CYC_W+SIG_W  record = {kind, cycle, payload}.
- overflow  out  1  sticky: at least one data record was dropped.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset values:
  - state = IDLE; cycle counter, count, overflow = 0; rec_valid = 0; rec_data = 0.
  - start_cycle and stop_cycle latches = 0.
  - Reset asserted mid-record flushes the FIFO; no partial record survives.
- Cycle counter:
  - Increments on each tgt_fire, in every state, and wraps modulo 2^CYC_W.
  - A record's timestamp is the counter value before the increment.
- FSM:
  - IDLE: on arm, latch start_cycle/stop_cycle and go to ARMED.
  - ARMED: on tgt_fire with cycle >= start_cycle, capture this cycle and go to RECORD. If this cycle is also >= stop_cycle or has exit, go straight to DONE.
  - RECORD: capture on each tgt_fire. Go to DONE after capturing cycle == stop_cycle, or on exit.
  - DONE: arm is honoured only when count == 0; it then re-latches and goes to ARMED. Otherwise arm is ignored.
  - arm in ARMED or RECORD is ignored.
- Record format:
  - Data record: kind = 0, payload = sig_in.
  - Exit record: kind = 1, payload = exitcode zero-extended to SIG_W.
  - With exit and tgt_fire together in ARMED or RECORD, only the exit record is written, not a data record.
  - exit in IDLE or DONE is ignored.
- Full rule:
  - One slot is reserved for the exit marker: data records are written only when count < DEPTH-1.
  - A data record refused at count >= DEPTH-1 is dropped and sets overflow; overflow is cleared only by reset or an honoured arm.
  - The exit record is written while count < DEPTH, so it is never lost.
- FIFO:
  - Show-ahead: rec_valid = (count != 0), and rec_data is the head entry.
  - Pop when rec_valid && rec_ready. A push and pop in the same cycle leaves count unchanged, including at count == DEPTH-1.
  - Pointers wrap modulo DEPTH.
  - Write latency is 1: a record captured at edge N is visible on rec_valid/rec_data after edge N, when the FIFO was empty.
- stop_cycle < start_cycle: exactly one record is captured, at trigger.

Optional Feature:
- Macro: IO_TRACE_RECORDER_DELTA_EN.
- Defined:
  - In RECORD, a data record is written only when sig_in differs from the last recorded sig_in.
  - The trigger cycle, the stop_cycle record and the exit record are always written.
  - Duplicates suppressed this way never set overflow.
- Undefined: every fired cycle in the window is recorded, and the comparison register is absent.

Decomposition:
- Package io_trace_recorder_pkg:
  - state enum {IDLE, ARMED, RECORD, DONE}.
  - Record kind constants KIND_DATA = 0, KIND_EXIT = 1.
  - A record-width function of CYC_W and SIG_W.
- Sub-module recorder_fifo: a parameterised show-ahead FIFO exposing count, with registered read data.

Test Plan:
- Arm with start=5, stop=8; fire every clock → records for cycles 5,6,7,8 with kind 0 and the matching sig_in; state ends in DONE; overflow = 0.
- DEPTH=16, rec_ready=0, window 0..40 → exactly 15 data records, overflow = 1. Then assert exit → a 16th record {1, cyc, exitcode} is written and count = 16.
- exit with exitcode=0x2A at cycle 3, window 0..100 → data records for cycles 0..2, then {1, 3, 0x2A}; no data record for cycle 3; state DONE.
- tgt_fire toggled 1,0,1 with window 0..1 → two records stamped 0 and 1; stall clocks produce nothing.
- Arm in DONE with count = 2 → ignored. Drain both records, then arm → state ARMED and overflow cleared.
- With IO_TRACE_RECORDER_DELTA_EN defined: sig_in = A,A,A,B over window 0..3 → records at cycles 0 (A), 3 (B). Cycle 3 is also the stop cycle, so exactly 2 records.

Source files
------------

// File: rtl/io_trace_recorder_pkg.sv
// Shared types for the trace recorder: FSM states, record kinds, record width.
package io_trace_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic KIND_DATA = 1'b0;
  localparam logic KIND_EXIT = 1'b1;

  function automatic int rec_width(input int cyc_w, input int sig_w);
    return 1 + cyc_w + sig_w;
  endfunction

endpackage

// File: rtl/recorder_fifo.sv
// Show-ahead ring FIFO with registered head data and an occupancy count.
// Latency: a push into an empty FIFO is visible on rdata/count after one edge.
// Backpressure: pushes while full are discarded; pops while empty are ignored.
module recorder_fifo #(
  parameter int W     = 97,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   count_nxt;
  logic          do_push, do_pop;

  always_comb begin
    do_pop     = pop && (count != '0);
    do_push    = push && ((count != FULL) || do_pop);
    rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = count;
    if (do_push && !do_pop)
      count_nxt = count + (AW+1)'(1);
    else if (!do_push && do_pop)
      count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      // Bypass the incoming word when it becomes the new head; hold when empty.
      if (count_nxt != '0)
        rdata <= (do_push && (wr_ptr == rd_ptr_nxt)) ? wdata : mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/io_trace_recorder.sv
// Captures timestamped sig_in snapshots (plus an exit marker) over an armed cycle window into a FIFO.
// Latency: a captured record reaches rec_valid/rec_data one edge later; IO_TRACE_RECORDER_DELTA_EN drops repeats.
// Backpressure: rec_ready drains the FIFO; data is dropped (sticky overflow) above DEPTH-1, exit always fits.
module io_trace_recorder
  import io_trace_recorder_pkg::*;
#(
  parameter int SIG_W = 64,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 tgt_fire,
  input  logic [SIG_W-1:0]                     sig_in,
  input  logic                                 exit,
  input  logic [31:0]                          exitcode,
  input  logic                                 arm,
  input  logic [CYC_W-1:0]                     start_cycle,
  input  logic [CYC_W-1:0]                     stop_cycle,
  output logic                                 rec_valid,
  input  logic                                 rec_ready,
  output logic [rec_width(CYC_W, SIG_W)-1:0]   rec_data,
  output logic                                 overflow,
  output logic [$clog2(DEPTH):0]               count,
  output logic [1:0]                           state
);

  localparam int REC_W = rec_width(CYC_W, SIG_W);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] DATA_LIM = CW'(DEPTH - 1);

  state_e           st;
  logic [CYC_W-1:0] cycle, start_q, stop_q;
  logic             cap, at_stop, keep, want_data, data_room, is_exit, push, pop;
  logic [REC_W-1:0] wdata;

`ifdef IO_TRACE_RECORDER_DELTA_EN
  logic [SIG_W-1:0] last_sig;
`endif

  always_comb begin
    cap       = tgt_fire && (((st == ARMED) && (cycle >= start_q)) || (st == RECORD));
    at_stop   = (st == ARMED) ? (cycle >= stop_q) : (cycle == stop_q);
`ifdef IO_TRACE_RECORDER_DELTA_EN
    // Trigger and stop-cycle records are unconditional; only mid-window repeats are suppressed.
    keep      = (st != RECORD) || at_stop || (sig_in != last_sig);
`else
    keep      = 1'b1;
`endif
    is_exit   = cap && exit;
    want_data = cap && !exit && keep;
    data_room = count < DATA_LIM;
    push      = is_exit ? (count != FULL) : (want_data && data_room);
    wdata     = is_exit ? {KIND_EXIT, cycle, SIG_W'(exitcode)} : {KIND_DATA, cycle, sig_in};
    rec_valid = count != '0;
    pop       = rec_valid && rec_ready;
    state     = st;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st       <= IDLE;
      cycle    <= '0;
      start_q  <= '0;
      stop_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (tgt_fire)
        cycle <= cycle + CYC_W'(1);
      if (want_data && !data_room)
        overflow <= 1'b1;
      case (st)
        IDLE, DONE: begin
          if (arm && ((st == IDLE) || (count == '0))) begin
            start_q  <= start_cycle;
            stop_q   <= stop_cycle;
            overflow <= 1'b0;
            st       <= ARMED;
          end
        end
        ARMED, RECORD: begin
          if (cap)
            st <= (exit || at_stop) ? DONE : RECORD;
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef IO_TRACE_RECORDER_DELTA_EN
  always_ff @(posedge clock) begin
    if (reset)
      last_sig <= '0;
    else if (push && !is_exit)
      last_sig <= sig_in;
  end
`endif

  recorder_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rec_data),
    .count (count)
  );

endmodule
